// File: rtl/tetris_input_if.sv
// Command-source bundle between the player/timing side and tetris_input_ctrl.
// ctrl is a one-cycle pulse per command. No ready signal exists because the guard gap enforces spacing.
interface tetris_input_if;
  logic [5:0] btn;
  logic       start;
  logic       run;
  logic [3:0] speed;
  logic       flush;
  logic [2:0] ctrl;
  logic       busy;
  logic [2:0] q_count;

  modport master (
    output btn, start, run, speed, flush,
    input  ctrl, busy, q_count
  );

  modport slave (
    input  btn, start, run, speed, flush,
    output ctrl, busy, q_count
  );
endinterface

// File: rtl/tetris_input_ctrl.sv
// Turns presses, auto-repeat and gravity into spaced one-cycle ctrl codes.
// Events land in pending flags, drain by priority into a small FIFO, and issue behind a guard gap.
module tetris_input_ctrl #(
  parameter int GAP       = 4,
  parameter int DROP_GAP  = 48,
  parameter int GRAV_BASE = 50000000,
  parameter int DAS_DLY   = 12000000,
  parameter int DAS_RATE  = 3000000,
  parameter int QDEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  tetris_input_if.slave io
);
  localparam int GW   = $clog2(GRAV_BASE + 1);
  localparam int DW   = $clog2(DAS_DLY + 1);
  localparam int GMAX = (DROP_GAP > GAP) ? DROP_GAP : GAP;
  localparam int XW   = $clog2(GMAX + 1);
  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = $clog2(QDEPTH) + 1;

  logic [5:0]    btn_prev_q, btn_prev_d;
  logic          start_prev_q, start_prev_d;
  logic [DW-1:0] das_cnt_q [3];
  logic [DW-1:0] das_cnt_d [3];
  logic [2:0]    das_rep_q, das_rep_d, das_ev;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d, grav_shift, grav_period;
  logic          grav_ev;
  logic [7:0]    flag_q, flag_d, ev, enq_sel;
  logic [2:0]    mem_q [QDEPTH];
  logic [2:0]    mem_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] gap_q, gap_d;
  logic [2:0]    ctrl_q, ctrl_d, enq_idx, enq_code, head;
  logic [5:0]    press;
  logic [2:0]    held;
  logic          start_press, found, full, do_push, do_pop;

  // Flag index order is also priority order: 0 start .. 7 grav.
  function automatic logic [2:0] src_code(input logic [2:0] idx);
    case (idx)
      3'd0:    src_code = 3'd7;
      3'd1:    src_code = 3'd6;
      3'd2:    src_code = 3'd1;
      3'd3:    src_code = 3'd2;
      3'd4:    src_code = 3'd3;
      3'd5:    src_code = 3'd4;
      default: src_code = 3'd5;
    endcase
  endfunction

  assign press        = io.btn & ~btn_prev_q;
  assign start_press  = io.start & ~start_prev_q;
  assign held         = io.btn[4:2] & btn_prev_q[4:2];
  assign btn_prev_d   = io.btn;
  assign start_prev_d = io.start;

  // Repeat counters start the cycle after the press, so the first repeat lands DAS_DLY after it.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      das_cnt_d[i] = das_cnt_q[i];
      das_rep_d[i] = das_rep_q[i];
      das_ev[i]    = 1'b0;
      if (!(io.run && held[i])) begin
        das_cnt_d[i] = '0;
        das_rep_d[i] = 1'b0;
      end else if (!das_rep_q[i]) begin
        if (das_cnt_q[i] == DW'(DAS_DLY - 1)) begin
          das_ev[i]    = 1'b1;
          das_rep_d[i] = 1'b1;
          das_cnt_d[i] = '0;
        end else begin
          das_cnt_d[i] = das_cnt_q[i] + DW'(1);
        end
      end else if (das_cnt_q[i] == DW'(DAS_RATE - 1)) begin
        das_ev[i]    = 1'b1;
        das_cnt_d[i] = '0;
      end else begin
        das_cnt_d[i] = das_cnt_q[i] + DW'(1);
      end
    end
  end

  // >= keeps a shortened period from skipping its compare after a speed change.
  always_comb begin
    grav_shift  = GW'(GRAV_BASE) >> io.speed;
    grav_period = (grav_shift < GW'(DROP_GAP + 1)) ? GW'(DROP_GAP + 1) : grav_shift;
    grav_ev     = io.run && (grav_cnt_q >= grav_period - GW'(1));
    grav_cnt_d  = (!io.run || grav_ev) ? '0 : grav_cnt_q + GW'(1);
  end

  assign ev = {grav_ev, das_ev[2] | press[4], das_ev[1] | press[3], das_ev[0] | press[2],
               press[1], press[0], press[5], start_press};

  always_comb begin
    found   = 1'b0;
    enq_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (flag_q[i]) begin
        found   = 1'b1;
        enq_idx = 3'(i);
      end
    end
    enq_sel  = 8'd1 << enq_idx;
    enq_code = src_code(enq_idx);
  end

  assign full    = (cnt_q == CW'(QDEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_push = found && !full && !io.flush;
  assign do_pop  = (gap_q == '0) && (cnt_q != '0) && !io.flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ctrl_d   = 3'd0;
    if (io.flush) begin
      flag_d   = (flag_q | ev) & 8'h01;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      flag_d = (flag_q & ~(do_push ? enq_sel : 8'h00)) | ev;
      if (do_push) begin
        mem_d[wr_ptr_q] = enq_code;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
    if (do_pop) begin
      ctrl_d = head;
      gap_d  = (head == 3'd6) ? XW'(DROP_GAP) : XW'(GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - XW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev_q   <= '0;
      start_prev_q <= 1'b0;
      das_rep_q    <= '0;
      grav_cnt_q   <= '0;
      flag_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      ctrl_q       <= 3'd0;
      for (int i = 0; i < 3; i++) das_cnt_q[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 3'd0;
    end else begin
      btn_prev_q   <= btn_prev_d;
      start_prev_q <= start_prev_d;
      das_rep_q    <= das_rep_d;
      das_cnt_q    <= das_cnt_d;
      grav_cnt_q   <= grav_cnt_d;
      flag_q       <= flag_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign io.ctrl    = ctrl_q;
  assign io.busy    = (gap_q != '0);
  assign io.q_count = 3'(cnt_q);
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl: every nonzero ctrl is logged with its cycle number
// and compared against hand-computed {cycle, code} entries.
module tb_tetris_input_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n;
  int   qmax = 0;
  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tetris_input_if io();

  tetris_input_ctrl #(
    .GAP(4), .DROP_GAP(48), .GRAV_BASE(100), .DAS_DLY(20), .DAS_RATE(5), .QDEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io.slave)
  );

  always @(negedge clk) begin
    if (io.ctrl != 3'd0) obs_q.push_back({32'(cyc), io.ctrl});
    if (int'(io.q_count) > qmax) qmax = int'(io.q_count);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int t, input logic [2:0] c);
    exp_q.push_back({32'(t), c});
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 35'(obs_q.size()), 35'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    io.btn   = 6'd0;
    io.start = 1'b0;
    io.run   = 1'b0;
    io.speed = 4'd0;
    io.flush = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    obs_q.delete();
    exp_q.delete();
    qmax = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_ctrl", 35'(io.ctrl), 35'd0);
    chk("rst_busy", 35'(io.busy), 35'd0);
    chk("rst_qcount", 35'(io.q_count), 35'd0);

    // Single left press: ctrl at E3, busy for GAP cycles.
    io.btn = 6'b000100;
    step(); io.btn = 6'd0;
    chk("t1_q_e1", 35'(io.q_count), 35'd0);
    step();
    chk("t1_ctrl_e2", 35'(io.ctrl), 35'd0);
    chk("t1_q_e2", 35'(io.q_count), 35'd1);
    step();
    chk("t1_ctrl_e3", 35'(io.ctrl), 35'd3);
    chk("t1_busy_e3", 35'(io.busy), 35'd1);
    chk("t1_q_e3", 35'(io.q_count), 35'd0);
    step();
    chk("t1_ctrl_e4", 35'(io.ctrl), 35'd0);
    step(); step();
    chk("t1_busy_e6", 35'(io.busy), 35'd1);
    step();
    chk("t1_busy_e7", 35'(io.busy), 35'd0);
    repeat (20) step();
    chk("t1_pulses", 35'(obs_q.size()), 35'd1);

    // hold, rotate, right together: priority order, GAP+1 spacing.
    do_reset();
    n = cyc;
    io.btn = 6'b001011;
    step(); io.btn = 6'd0;
    repeat (30) step();
    expect_ev(n + 3, 3'd1);
    expect_ev(n + 8, 3'd2);
    expect_ev(n + 13, 3'd4);
    check_log("t2");
    chk("t2_qmax", 35'(qmax), 35'd2);

    // Drop then left: DROP_GAP idle cycles after the drop.
    do_reset();
    n = cyc;
    io.btn = 6'b100000;
    step(); io.btn = 6'b000100;
    step(); io.btn = 6'd0;
    repeat (60) step();
    expect_ev(n + 3, 3'd6);
    expect_ev(n + 52, 3'd3);
    check_log("t3");

    // Held right with run: press, +20, then every 5 until release.
    do_reset();
    n = cyc;
    io.run = 1'b1;
    io.btn = 6'b001000;
    repeat (36) step();
    io.btn = 6'd0;
    repeat (30) step();
    io.run = 1'b0;
    expect_ev(n + 3, 3'd4);
    expect_ev(n + 23, 3'd4);
    expect_ev(n + 28, 3'd4);
    expect_ev(n + 33, 3'd4);
    expect_ev(n + 38, 3'd4);
    check_log("t5");

    // Gravity at speed 0: period 100.
    do_reset();
    n = cyc;
    io.run = 1'b1;
    repeat (210) step();
    expect_ev(n + 102, 3'd5);
    expect_ev(n + 202, 3'd5);
    check_log("t4a");

    // Gravity at speed 15: clamped to DROP_GAP+1 = 49.
    do_reset();
    n = cyc;
    io.speed = 4'd15;
    io.run   = 1'b1;
    repeat (160) step();
    io.run = 1'b0;
    expect_ev(n + 51, 3'd5);
    expect_ev(n + 100, 3'd5);
    expect_ev(n + 149, 3'd5);
    check_log("t4b");

    // Fill FIFO behind a drop gap, pend start, then flush.
    do_reset();
    n = cyc;
    io.btn = 6'b111111;
    step(); io.btn = 6'd0;
    repeat (5) step();
    chk("t6_q_full", 35'(io.q_count), 35'd4);
    io.start = 1'b1;
    step(); io.start = 1'b0; io.flush = 1'b1;
    chk("t6_q_still_full", 35'(io.q_count), 35'd4);
    step(); io.flush = 1'b0;
    chk("t6_q_flushed", 35'(io.q_count), 35'd0);
    chk("t6_busy_kept", 35'(io.busy), 35'd1);
    step();
    chk("t6_q_start", 35'(io.q_count), 35'd1);
    repeat (60) step();
    expect_ev(n + 3, 3'd6);
    expect_ev(n + 52, 3'd7);
    check_log("t6");

    // Async reset in the middle of a drop gap.
    do_reset();
    io.btn = 6'b100000;
    step(); io.btn = 6'd0;
    repeat (4) step();
    chk("t7_busy_before", 35'(io.busy), 35'd1);
    reset = 1'b1;
    #1;
    chk("t7_busy_reset", 35'(io.busy), 35'd0);
    chk("t7_ctrl_reset", 35'(io.ctrl), 35'd0);
    step(); step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
